// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: car-signal phase FSM, 1 s countdown and
// latched pedestrian requests feeding one walk enable per direction.
module intersection_controller #(
    parameter int CLK_PER_SEC  = 50_000_000,
    parameter int GREEN_TIME   = 60,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_request_ns,
    input  logic       ped_request_ew,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] master_timer,
    output logic       ns_walk_enable,
    output logic       ew_walk_enable,
    output logic       second_tick
);

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        RED1,
        EW_GREEN,
        EW_YELLOW,
        RED2
    } state_t;

    localparam int              PS_W        = $clog2(CLK_PER_SEC);
    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(CLK_PER_SEC - 1);
    localparam logic [6:0]      GREEN_LOAD  = 7'(GREEN_TIME - 1);
    localparam logic [6:0]      YELLOW_LOAD = 7'(YELLOW_TIME - 1);
    localparam logic [6:0]      RED_LOAD    = 7'(ALL_RED_TIME - 1);
    localparam logic [2:0]      LIGHT_RED   = 3'b100;
    localparam logic [2:0]      LIGHT_YEL   = 3'b010;
    localparam logic [2:0]      LIGHT_GRN   = 3'b001;

    state_t          state_reg;
    logic [PS_W-1:0] prescale_reg;
    logic            tick_reg;
    logic [6:0]      timer_reg;
    logic [2:0]      ns_light_reg;
    logic [2:0]      ew_light_reg;

    logic       tick_now;
    logic       advance;
    logic [1:0] ped_request;
    logic [1:0] enter_green;
    logic [1:0] leave_green;
    logic [1:0] in_green;
    logic [1:0] walk_vec;

    // The FSM acts in the same edge that raises second_tick, so the tick and
    // the timer/light change become visible together.
    assign tick_now    = (prescale_reg == PS_LAST);
    assign advance     = tick_now && (timer_reg == 7'd0);
    assign ped_request = {ped_request_ew, ped_request_ns};

    assign enter_green[0] = advance && (state_reg == RED2);
    assign enter_green[1] = advance && (state_reg == RED1);
    assign leave_green[0] = advance && (state_reg == NS_GREEN);
    assign leave_green[1] = advance && (state_reg == EW_GREEN);
    assign in_green[0]    = (state_reg == NS_GREEN);
    assign in_green[1]    = (state_reg == EW_GREEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_reg <= '0;
            tick_reg     <= 1'b0;
        end else if (tick_now) begin
            prescale_reg <= '0;
            tick_reg     <= 1'b1;
        end else begin
            prescale_reg <= prescale_reg + 1'b1;
            tick_reg     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RED2;
            timer_reg    <= RED_LOAD;
            ns_light_reg <= LIGHT_RED;
            ew_light_reg <= LIGHT_RED;
        end else if (tick_now) begin
            if (timer_reg != 7'd0) begin
                timer_reg <= timer_reg - 7'd1;
            end else begin
                case (state_reg)
                    RED2: begin
                        state_reg    <= NS_GREEN;
                        timer_reg    <= GREEN_LOAD;
                        ns_light_reg <= LIGHT_GRN;
                        ew_light_reg <= LIGHT_RED;
                    end
                    NS_GREEN: begin
                        state_reg    <= NS_YELLOW;
                        timer_reg    <= YELLOW_LOAD;
                        ns_light_reg <= LIGHT_YEL;
                        ew_light_reg <= LIGHT_RED;
                    end
                    NS_YELLOW: begin
                        state_reg    <= RED1;
                        timer_reg    <= RED_LOAD;
                        ns_light_reg <= LIGHT_RED;
                        ew_light_reg <= LIGHT_RED;
                    end
                    RED1: begin
                        state_reg    <= EW_GREEN;
                        timer_reg    <= GREEN_LOAD;
                        ns_light_reg <= LIGHT_RED;
                        ew_light_reg <= LIGHT_GRN;
                    end
                    EW_GREEN: begin
                        state_reg    <= EW_YELLOW;
                        timer_reg    <= YELLOW_LOAD;
                        ns_light_reg <= LIGHT_RED;
                        ew_light_reg <= LIGHT_YEL;
                    end
                    default: begin
                        state_reg    <= RED2;
                        timer_reg    <= RED_LOAD;
                        ns_light_reg <= LIGHT_RED;
                        ew_light_reg <= LIGHT_RED;
                    end
                endcase
            end
        end
    end

    // Index 0 is NS, index 1 is EW; both directions share identical request logic.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            logic pend_reg;
            logic walk_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_reg <= 1'b0;
                    walk_reg <= 1'b0;
                end else if (enter_green[gi]) begin
                    // A press in the grant clk itself still earns the walk.
                    if (pend_reg || ped_request[gi]) begin
                        walk_reg <= 1'b1;
                        pend_reg <= 1'b0;
                    end
                end else begin
                    if (leave_green[gi]) begin
                        walk_reg <= 1'b0;
                    end
                    if (ped_request[gi] && !(in_green[gi] && walk_reg)) begin
                        pend_reg <= 1'b1;
                    end
                end
            end

            assign walk_vec[gi] = walk_reg;
        end
    endgenerate

    assign ns_light       = ns_light_reg;
    assign ew_light       = ew_light_reg;
    assign master_timer   = timer_reg;
    assign second_tick    = tick_reg;
    assign ns_walk_enable = walk_vec[0];
    assign ew_walk_enable = walk_vec[1];

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed scenarios plus random button
// traffic, compared each clk against a seconds-level phase model.
module tb_intersection_controller;

    localparam int CPS = 4;
    localparam int GT  = 40;
    localparam int YT  = 3;
    localparam int AR  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ped_request_ns = 1'b0;
    logic       ped_request_ew = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [6:0] master_timer;
    logic       ns_walk_enable;
    logic       ew_walk_enable;
    logic       second_tick;

    int errors = 0;
    int checks = 0;

    intersection_controller #(
        .CLK_PER_SEC (CPS),
        .GREEN_TIME  (GT),
        .YELLOW_TIME (YT),
        .ALL_RED_TIME(AR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ped_request_ns(ped_request_ns),
        .ped_request_ew(ped_request_ew),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .master_timer  (master_timer),
        .ns_walk_enable(ns_walk_enable),
        .ew_walk_enable(ew_walk_enable),
        .second_tick   (second_tick)
    );

    always #5 clk = ~clk;

    // Phase order 0..5: NS_G, NS_Y, RED1, EW_G, EW_Y, RED2.
    int         dur    [6] = '{GT, YT, AR, GT, YT, AR};
    logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    int m_phase;
    int m_rem;
    int m_cnt;
    bit m_tick;
    bit m_entered;
    bit m_pend [2];
    bit m_walk [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_step(input bit rq_ns, input bit rq_ew, input bit rst);
        bit rq [2];
        bit wrap;
        rq[0] = rq_ns;
        rq[1] = rq_ew;
        m_entered = 0;
        if (rst) begin
            m_phase = 5;
            m_rem   = AR - 1;
            m_cnt   = 0;
            m_tick  = 0;
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 0;
                m_walk[d] = 0;
            end
        end else begin
            wrap = (m_cnt == CPS - 1);
            for (int d = 0; d < 2; d++)
                if (rq[d] && !(m_phase == 3 * d && m_walk[d])) m_pend[d] = 1;
            m_cnt  = wrap ? 0 : m_cnt + 1;
            m_tick = wrap;
            if (wrap) begin
                if (m_rem > 0) begin
                    m_rem--;
                end else begin
                    m_phase   = (m_phase + 1) % 6;
                    m_rem     = dur[m_phase] - 1;
                    m_entered = 1;
                    for (int d = 0; d < 2; d++) begin
                        if (m_phase == 3 * d && m_pend[d]) begin
                            m_walk[d] = 1;
                            m_pend[d] = 0;
                        end
                        if (m_phase == 3 * d + 1) m_walk[d] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit rq_ns, input bit rq_ew, input bit rst);
        ped_request_ns = rq_ns;
        ped_request_ew = rq_ew;
        reset          = rst;
        @(posedge clk);
        m_step(rq_ns, rq_ew, rst);
        #1;
        chk("ns_light", ns_light, ns_tab[m_phase]);
        chk("ew_light", ew_light, ew_tab[m_phase]);
        chk("master_timer", master_timer, m_rem);
        chk("second_tick", second_tick, m_tick);
        chk("ns_walk", ns_walk_enable, m_walk[0]);
        chk("ew_walk", ew_walk_enable, m_walk[1]);
        chk("walk_exclusive", ns_walk_enable & ew_walk_enable, 0);
    endtask

    task automatic run_to(input int ph, input string tag);
        bit found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cyc(0, 0, 0);
            if (m_entered && m_phase == ph) found = 1;
        end
        chk({tag, "_reached"}, found, 1);
    endtask

    // Release reset and check the start-up timing from fixed numbers.
    task automatic restart_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk({tag, "_no_tick"}, second_tick, 0);
        end
        cyc(0, 0, 0);
        chk({tag, "_tick1"}, second_tick, 1);
        chk({tag, "_tick1_timer"}, master_timer, 0);
        chk({tag, "_tick1_red"}, ns_light, 3'b100);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
        chk({tag, "_nsg_light"}, ns_light, 3'b001);
        chk({tag, "_nsg_ew"}, ew_light, 3'b100);
        chk({tag, "_nsg_timer"}, master_timer, 39);
    endtask

    initial begin
        int n_nsg, n_nsy, n_ewg, n_ewy, n_red;
        bit rq_a, rq_b, rs;

        // 1. reset for 3 clks then release
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        chk("t1_rst_timer", master_timer, 1);
        chk("t1_rst_ns", ns_light, 3'b100);
        chk("t1_rst_ew", ew_light, 3'b100);
        restart_check("t1");
        $display("t1 start-up sequence done, checks=%0d", checks);

        // 2. one full 90-tick cycle without requests
        n_nsg = 0; n_nsy = 0; n_ewg = 0; n_ewy = 0; n_red = 0;
        for (int i = 0; i < 90 * CPS; i++) begin
            cyc(0, 0, 0);
            if (ns_light == 3'b001) n_nsg++;
            if (ns_light == 3'b010) n_nsy++;
            if (ew_light == 3'b001) n_ewg++;
            if (ew_light == 3'b010) n_ewy++;
            if (ns_light == 3'b100 && ew_light == 3'b100) n_red++;
            chk("t2_no_walk", ns_walk_enable | ew_walk_enable, 0);
        end
        chk("t2_nsg_clks", n_nsg, GT * CPS);
        chk("t2_nsy_clks", n_nsy, YT * CPS);
        chk("t2_ewg_clks", n_ewg, GT * CPS);
        chk("t2_ewy_clks", n_ewy, YT * CPS);
        chk("t2_allred_clks", n_red, 2 * AR * CPS);
        $display("t2 free-run cycle done, checks=%0d", checks);

        // 3. NS pulse during EW green
        run_to(3, "t3_ewg");
        cyc(1, 0, 0);
        run_to(0, "t3_nsg");
        chk("t3_walk_on", ns_walk_enable, 1);
        chk("t3_walk_timer", master_timer, 39);
        run_to(1, "t3_nsy");
        chk("t3_walk_off", ns_walk_enable, 0);
        run_to(0, "t3_nsg2");
        chk("t3_no_rewalk", ns_walk_enable, 0);
        $display("t3 ns walk grant done, checks=%0d", checks);

        // 4. EW request held through an active EW walk is absorbed
        cyc(0, 1, 0);
        run_to(3, "t4_ewg");
        chk("t4_walk_on", ew_walk_enable, 1);
        for (int i = 0; i < 400 && m_phase == 3; i++) cyc(0, 1, 0);
        chk("t4_left_green", ew_light, 3'b010);
        run_to(3, "t4_ewg2");
        chk("t4_no_rewalk", ew_walk_enable, 0);
        $display("t4 absorbed request done, checks=%0d", checks);

        // 5. request only in the RED2->NS_GREEN clk
        run_to(5, "t5_red2");
        for (int i = 0; i < 100 && !(m_rem == 0 && m_cnt == CPS - 1); i++) cyc(0, 0, 0);
        chk("t5_pre_walk", ns_walk_enable, 0);
        cyc(1, 0, 0);
        chk("t5_nsg", ns_light, 3'b001);
        chk("t5_walk_on", ns_walk_enable, 1);
        $display("t5 entry-clk request done, checks=%0d", checks);

        // 6. reset in EW green at timer 17 with EW walk active
        cyc(0, 1, 0);
        run_to(3, "t6_ewg");
        chk("t6_walk_on", ew_walk_enable, 1);
        for (int i = 0; i < 400 && m_rem != 17; i++) cyc(0, 0, 0);
        chk("t6_timer17", master_timer, 17);
        cyc(0, 0, 1);
        chk("t6_rst_timer", master_timer, 1);
        chk("t6_rst_ns", ns_light, 3'b100);
        chk("t6_rst_ew", ew_light, 3'b100);
        chk("t6_rst_walk", ew_walk_enable, 0);
        chk("t6_rst_tick", second_tick, 0);
        restart_check("t6");
        $display("t6 mid-phase reset done, checks=%0d", checks);

        // random button traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rq_a = ($urandom_range(0, 29) == 0);
            rq_b = ($urandom_range(0, 29) == 0);
            rs   = ($urandom_range(0, 999) == 0);
            cyc(rq_a, rq_b, rs);
        end
        $display("random traffic done, checks=%0d", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
